// File: rtl/ddr_instr_pkg.sv
// ddr_instr_pkg: instruction-slot layout, opcodes and refresh FSM states shared by
// ddr_refresh_scheduler and ddr_refresh_timer.
package ddr_instr_pkg;

  localparam int SLOT_W    = 32;
  localparam int NUM_SLOTS = 4;
  localparam int OP_W      = 3;
  localparam int PEND_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_PRE = 3'd1;
  localparam logic [OP_W-1:0] OP_ACT = 3'd2;
  localparam logic [OP_W-1:0] OP_RD  = 3'd3;
  localparam logic [OP_W-1:0] OP_WR  = 3'd4;
  localparam logic [OP_W-1:0] OP_REF = 3'd5;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_PREA,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } ref_state_t;

  // The all-banks flag sits just above the opcode, bank and bank-group fields of a slot.
  function automatic int pall_bit(input int bank_width, input int bg_width);
    return OP_W + bank_width + bg_width;
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// ddr_refresh_timer: tREFI interval counter and saturating count of refreshes that are
// due but not yet issued.
module ddr_refresh_timer
  import ddr_instr_pkg::*;
#(
  parameter int TREFI       = 7800,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_en,
  input  logic              ref_done,
  output logic [PEND_W-1:0] ref_pending
);

  localparam int IV_W = $clog2(TREFI);

  logic [IV_W-1:0] iv;
  logic            due;

  assign due = (iv == IV_W'(TREFI - 1));

  always_ff @(posedge clk) begin
    if (rst || !ref_en) begin
      iv          <= '0;
      ref_pending <= '0;
    end else begin
      iv <= due ? '0 : iv + 1'b1;
      // A due event coinciding with an issued REF cancels out.
      if (due && !ref_done) begin
        if (ref_pending != PEND_W'(MAX_PENDING))
          ref_pending <= ref_pending + 1'b1;
      end else if (ref_done && !due && (ref_pending != '0)) begin
        ref_pending <= ref_pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_refresh_scheduler.sv
// ddr_refresh_scheduler: splices PREA/REF pairs into the 128-bit host instruction stream.
// Build option DDR_REF_POSTPONE_EN defers refreshes while the host is streaming.
module ddr_refresh_scheduler
  import ddr_instr_pkg::*;
#(
  parameter int BG_WIDTH    = 2,
  parameter int BANK_WIDTH  = 2,
  parameter int TREFI       = 7800,
  parameter int TRP         = 12,
  parameter int TRFC        = 280,
  parameter int MAX_PENDING = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ref_en,
  input  logic [127:0] S_AXIS_TDATA,
  input  logic         S_AXIS_TVALID,
  output logic         S_AXIS_TREADY,
  output logic [127:0] M_AXIS_TDATA,
  output logic         M_AXIS_TVALID,
  input  logic         M_AXIS_TREADY,
  output logic [3:0]   ref_pending,
  output logic         ref_busy
);

  localparam int PKT_W    = SLOT_W * NUM_SLOTS;
  localparam int WAIT_MAX = (TRFC > TRP) ? TRFC : TRP;
  localparam int WC_W     = $clog2(WAIT_MAX) + 1;
  localparam int PALL     = pall_bit(BANK_WIDTH, BG_WIDTH);

  ref_state_t       state;
  logic [WC_W-1:0]  wcnt;
  logic [PKT_W-1:0] pkt_q;
  logic             vld_q;
  logic             busy_q;
  logic             pass_q;

  logic             ref_done;
  logic             start;
  logic             pass_sel;
  logic [PKT_W-1:0] prea_pkt;
  logic [PKT_W-1:0] ref_pkt;

  ddr_refresh_timer #(
    .TREFI       (TREFI),
    .MAX_PENDING (MAX_PENDING)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .ref_en      (ref_en),
    .ref_done    (ref_done),
    .ref_pending (ref_pending)
  );

  always_comb begin
    prea_pkt               = '0;
    prea_pkt[OP_W-1:0]     = OP_PRE;
    prea_pkt[PALL]         = 1'b1;
    ref_pkt                = '0;
    ref_pkt[OP_W-1:0]      = OP_REF;
  end

`ifdef DDR_REF_POSTPONE_EN
  assign start = (ref_pending != '0) &&
                 (!S_AXIS_TVALID || (ref_pending == 4'(MAX_PENDING)));
`else
  assign start = (ref_pending != '0);
`endif

  assign ref_done = (state == ST_REF) && M_AXIS_TREADY;

  // Reset forces pass-through combinationally so the host path is live before the first edge.
  assign pass_sel      = pass_q | rst;
  assign M_AXIS_TDATA  = pass_sel ? S_AXIS_TDATA  : pkt_q;
  assign M_AXIS_TVALID = pass_sel ? S_AXIS_TVALID : vld_q;
  assign S_AXIS_TREADY = pass_sel & M_AXIS_TREADY;
  assign ref_busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_PASS;
      wcnt   <= '0;
      pkt_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      pass_q <= 1'b1;
    end else begin
      case (state)
        ST_PASS: begin
          if (start) begin
            state  <= ST_PREA;
            pkt_q  <= prea_pkt;
            vld_q  <= 1'b1;
            busy_q <= 1'b1;
            pass_q <= 1'b0;
          end
        end
        ST_PREA: begin
          if (M_AXIS_TREADY) begin
            state <= ST_WAIT_RP;
            wcnt  <= WC_W'(TRP - 1);
            pkt_q <= '0;
            vld_q <= 1'b0;
          end
        end
        ST_WAIT_RP: begin
          if (wcnt == '0) begin
            state <= ST_REF;
            pkt_q <= ref_pkt;
            vld_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ST_REF: begin
          if (M_AXIS_TREADY) begin
            state <= ST_WAIT_RFC;
            wcnt  <= WC_W'(TRFC - 1);
            pkt_q <= '0;
            vld_q <= 1'b0;
          end
        end
        ST_WAIT_RFC: begin
          if (wcnt == '0) begin
            state  <= ST_PASS;
            busy_q <= 1'b0;
            pass_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_PASS;
          wcnt   <= '0;
          pkt_q  <= '0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          pass_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
